data_mem_responder: RTL and testbench

- Word-addressed data-memory responder: the target end of the CPU's load/store port.
- The CPU pipeline (MEM stage for LW/SW) initiates requests; this block accepts them, waits a configurable latency, then returns a response.
- Exactly one transaction outstanding at a time, with valid/ready handshakes on both request and response channels.
- All state updates on the falling edge of clock, matching the CPU pipeline registers.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_array.sv | 28 ++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: responder state encoding,
// word geometry and the address-error check used at request accept.
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A request is in error when it is not word aligned or when its full 30-bit
  // word index lies beyond the array; high address bits are never dropped, so
  // e.g. 0x8000_0010 is rejected rather than aliased onto word 4.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 word storage: synchronous write on the falling clock edge,
// asynchronous read. Contents are deliberately not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Commit a store on the falling edge, in step with the CPU pipeline.
  always_ff @(negedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Target end of the CPU load/store port. Accepts one request at a time,
// commits stores at the accept edge, waits LATENCY edges (the accept edge
// counts as the first) and then holds the response until the CPU takes it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; req_ready high
// WAIT  | request latched, cnt counting down to the response edge
// RESP  | resp_valid high, outputs held until resp_ready on a falling edge
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic write_q, write_d;
  logic err_q, err_d;
  logic resp_valid_d;
  logic resp_err_d;
  logic [31:0] resp_rdata_d;

  logic accept;
  logic req_err;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] rd_idx;
  logic [DATA_W-1:0] rd_data;

  assign req_err   = addr_err(req_addr, DEPTH);
  assign req_idx   = req_addr[AW+1:2];
  assign req_ready = resetn & (state == IDLE);
  assign accept    = req_valid & req_ready;

  // With LATENCY==1 the response is formed on the accept edge, so the read
  // port must look at the incoming address while idle.
  assign rd_idx = (state == IDLE) ? req_idx : idx_q;

  mem_array #(.DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .we    (accept & req_write & ~req_err),
    .waddr (req_idx),
    .wdata (req_wdata),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // Next-state, countdown and response formation.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    idx_d        = idx_q;
    write_d      = write_q;
    err_d        = err_q;
    resp_valid_d = resp_valid;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    unique case (state)
      IDLE: begin
        if (accept) begin
          idx_d   = req_idx;
          write_d = req_write;
          err_d   = req_err;
          if (LATENCY == 1) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = req_err;
            resp_rdata_d = (req_write | req_err) ? '0 : rd_data;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
          resp_rdata_d = (write_q | err_q) ? '0 : rd_data;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and response registers on the falling edge.
  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      err_q      <= err_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=1 instance, each
// checked every cycle against a transaction-level model, plus directed cases.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT0  = 2;
  localparam int LAT1  = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn;
  logic        req_valid  [2];
  logic        req_write  [2];
  logic        resp_ready [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic        resp_err   [2];
  logic [31:0] resp_rdata [2];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  function automatic int lat(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h expected %h", name, inst, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding request per instance; response
  // visible from edge accept+LAT-1, consumed on a later edge with resp_ready.
  int          edge_n   [2];
  int          acc_edge [2];
  int          rv_edge  [2];
  int          n_acc    [2];
  bit          pend     [2];
  bit          m_err    [2];
  bit          m_known  [2];
  logic [31:0] m_rdata  [2];
  logic [31:0] mem_m    [2][DEPTH];
  bit          known    [2][DEPTH];

  always @(negedge clock or negedge resetn) begin
    int widx;
    bit e;
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        pend[i] = 1'b0;
      end else begin
        edge_n[i]++;
        if (pend[i]) begin
          if (edge_n[i] > rv_edge[i] && resp_ready[i]) pend[i] = 1'b0;
        end else if (req_valid[i]) begin
          widx = int'(req_addr[i][31:2]);
          e = (req_addr[i][1:0] != 2'b00) || (widx >= DEPTH);
          m_err[i]   = e;
          m_rdata[i] = '0;
          m_known[i] = 1'b1;
          if (!e && req_write[i]) begin
            mem_m[i][widx] = req_wdata[i];
            known[i][widx] = 1'b1;
          end
          if (!e && !req_write[i]) begin
            m_rdata[i] = mem_m[i][widx];
            m_known[i] = known[i][widx];
          end
          pend[i]     = 1'b1;
          acc_edge[i] = edge_n[i];
          rv_edge[i]  = edge_n[i] + lat(i) - 1;
          n_acc[i]++;
        end
      end
    end
  end

  // Compare DUT outputs with the model mid-cycle.
  always @(posedge clock) begin
    bit ev;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        ev = pend[i] && (edge_n[i] >= rv_edge[i]);
        chk("req_ready", i, {31'b0, req_ready[i]}, {31'b0, resetn && !pend[i]});
        chk("resp_valid", i, {31'b0, resp_valid[i]}, {31'b0, ev});
        if (ev) begin
          chk("resp_err", i, {31'b0, resp_err[i]}, {31'b0, m_err[i]});
          if (m_known[i]) chk("resp_rdata", i, resp_rdata[i], m_rdata[i]);
        end else begin
          chk("idle_err", i, {31'b0, resp_err[i]}, 32'd0);
          chk("idle_rdata", i, resp_rdata[i], 32'd0);
        end
      end
    end
  end

  // Present a request at a posedge; returns at the posedge after acceptance.
  task automatic do_req(input int i, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output int acc);
    req_write[i] = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    req_valid[i] = 1'b1;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      if (req_ready[i]) break;
      @(posedge clock);
    end
    if (!req_ready[i]) begin
      chk("accept_timeout", i, {31'b0, req_ready[i]}, 32'd1);
      req_valid[i] = 1'b0;
    end else begin
      @(negedge clock);
      #1 acc = edge_n[i];
      @(posedge clock);
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_resp(input int i, input int acc, input logic [31:0] er,
                           input logic ee, input string tag);
    for (int k = 0; k < 50; k++) begin
      if (resp_valid[i]) break;
      @(posedge clock);
    end
    chk({tag, "_valid"}, i, {31'b0, resp_valid[i]}, 32'd1);
    chk({tag, "_latency"}, i, edge_n[i] - acc, lat(i) - 1);
    chk({tag, "_rdata"}, i, resp_rdata[i], er);
    chk({tag, "_err"}, i, {31'b0, resp_err[i]}, {31'b0, ee});
    resp_ready[i] = 1'b1;
    @(posedge clock);
    resp_ready[i] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    w = 32'($urandom_range(0, 15)) << 2;
    case ($urandom_range(0, 5))
      3:       return w | 32'($urandom_range(1, 3));
      4:       return 32'($urandom_range(DEPTH, DEPTH + 200)) << 2;
      5:       return 32'h8000_0000 | w;
      default: return w;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2, c;
    int last_acc [2];
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; resp_ready[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    @(posedge clock);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", i, {31'b0, req_ready[i]}, 32'd1);
      chk("rst_resp_valid", i, {31'b0, resp_valid[i]}, 32'd0);
      chk("rst_rdata", i, resp_rdata[i], 32'd0);
      chk("rst_err", i, {31'b0, resp_err[i]}, 32'd0);
    end

    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, a); wait_resp(0, a, 32'h0, 1'b0, "st");
    do_req(0, 1'b0, 32'h10, 32'h0, a);        wait_resp(0, a, 32'hDEADBEEF, 1'b0, "ld");
    do_req(0, 1'b1, 32'h12, 32'h12345678, a); wait_resp(0, a, 32'h0, 1'b1, "mis_st");
    do_req(0, 1'b0, 32'h10, 32'h0, a);        wait_resp(0, a, 32'hDEADBEEF, 1'b0, "ld2");
    do_req(0, 1'b0, 32'h1000, 32'h0, a);      wait_resp(0, a, 32'h0, 1'b1, "oor");
    do_req(0, 1'b0, 32'h80000010, 32'h0, a);  wait_resp(0, a, 32'h0, 1'b1, "alias");
    do_req(0, 1'b1, 32'hFFC, 32'h0BADF00D, a); wait_resp(0, a, 32'h0, 1'b0, "top_st");
    do_req(0, 1'b0, 32'hFFC, 32'h0, a);       wait_resp(0, a, 32'h0BADF00D, 1'b0, "top_ld");

    // Backpressure with a pending request behind the held response.
    do_req(0, 1'b0, 32'h10, 32'h0, a);
    for (int k = 0; k < 50; k++) begin
      if (resp_valid[0]) break;
      @(posedge clock);
    end
    chk("bp_valid", 0, {31'b0, resp_valid[0]}, 32'd1);
    req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h55; req_valid[0] = 1'b1;
    repeat (5) begin
      @(posedge clock);
      chk("bp_hold_valid", 0, {31'b0, resp_valid[0]}, 32'd1);
      chk("bp_hold_rdata", 0, resp_rdata[0], 32'hDEADBEEF);
      chk("bp_hold_err", 0, {31'b0, resp_err[0]}, 32'd0);
      chk("bp_hold_ready", 0, {31'b0, req_ready[0]}, 32'd0);
    end
    resp_ready[0] = 1'b1;
    @(posedge clock);
    resp_ready[0] = 1'b0;
    c = edge_n[0];
    chk("bp_released_ready", 0, {31'b0, req_ready[0]}, 32'd1);
    chk("bp_released_valid", 0, {31'b0, resp_valid[0]}, 32'd0);
    @(negedge clock);
    #1 chk("bp_next_accepted", 0, {31'b0, req_ready[0]}, 32'd0);
    @(posedge clock);
    req_valid[0] = 1'b0;
    wait_resp(0, c + 1, 32'h0, 1'b0, "bp_st");
    do_req(0, 1'b0, 32'h20, 32'h0, a); wait_resp(0, a, 32'h55, 1'b0, "bp_ld");

    // Reset while waiting: the load is dropped and never answered.
    do_req(0, 1'b0, 32'h10, 32'h0, a);
    #1 resetn = 1'b0;
    #1 chk("rstw_valid", 0, {31'b0, resp_valid[0]}, 32'd0);
    chk("rstw_ready_low", 0, {31'b0, req_ready[0]}, 32'd0);
    @(negedge clock);
    @(posedge clock);
    #1 resetn = 1'b1;
    @(posedge clock);
    chk("rstw_ready", 0, {31'b0, req_ready[0]}, 32'd1);
    repeat (8) begin
      @(posedge clock);
      chk("rstw_no_resp", 0, {31'b0, resp_valid[0]}, 32'd0);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, a); wait_resp(0, a, 32'hDEADBEEF, 1'b0, "rstw_ld");

    // LATENCY=1 instance.
    do_req(1, 1'b1, 32'h0, 32'h0000000F, a); wait_resp(1, a, 32'h0, 1'b0, "l1_st");
    do_req(1, 1'b0, 32'h0, 32'h0, a);        wait_resp(1, a, 32'h0000000F, 1'b0, "l1_ld");
    resp_ready[1] = 1'b1;
    do_req(1, 1'b1, 32'h4, 32'h0000A5A5, a);
    do_req(1, 1'b0, 32'h4, 32'h0, a2);
    chk("l1_spacing", 1, a2 - a, 32'd2);
    chk("l1_b2b_valid", 1, {31'b0, resp_valid[1]}, 32'd1);
    chk("l1_b2b_rdata", 1, resp_rdata[1], 32'h0000A5A5);
    @(posedge clock);
    resp_ready[1] = 1'b0;

    // Randomized traffic on both instances.
    last_acc[0] = n_acc[0];
    last_acc[1] = n_acc[1];
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        resp_ready[i] = ($urandom_range(0, 3) != 0);
        if (req_valid[i] && n_acc[i] != last_acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_write[i] = ($urandom_range(0, 1) == 1);
          req_addr[i]  = rand_addr();
          req_wdata[i] = $urandom;
          req_valid[i] = 1'b1;
          last_acc[i]  = n_acc[i];
        end
      end
      @(posedge clock);
    end
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      resp_ready[i] = 1'b1;
    end
    repeat (20) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
